kbd_event_decoder: RTL and testbench

- Parametrised successor to the single-register keyboard decoder. Sits between `ps2_keyboard` and the display/text consumers.
- Drains raw PS/2 set-2 scancodes through the `ready`/`nextdata_n` handshake.
- Runs a prefix state machine (E0/F0), tracks modifier and lock state, and maps each key to ASCII.
- Queues complete make/break events in an event FIFO of configurable depth, with backpressure toward the keyboard.

---
 rtl/kbd_pkg.sv | 37 +++
 rtl/kbd_ascii_map.sv | 63 ++++++
 rtl/kbd_event_decoder.sv | 188 ++++++++++++++++++
 tb/tb_kbd_event_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, FSM state encoding and event record for the PS/2 set-2 event decoder.
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } kbd_evt_t;

    // Keyboard status/ack bytes that carry no key information.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: is_ctrl_byte = 1'b1;
            default:                           is_ctrl_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kbd_ascii_map.sv
// Combinational set-2 scancode to ASCII translation using the current shift and caps-lock levels.
module kbd_ascii_map
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0]  letter_s;
    logic [15:0] sym_s;

    // Lowercase letter lookup; zero means the code is not a letter.
    always_comb begin
        case (code)
            8'h1C: letter_s = 8'h61;  8'h32: letter_s = 8'h62;  8'h21: letter_s = 8'h63;
            8'h23: letter_s = 8'h64;  8'h24: letter_s = 8'h65;  8'h2B: letter_s = 8'h66;
            8'h34: letter_s = 8'h67;  8'h33: letter_s = 8'h68;  8'h43: letter_s = 8'h69;
            8'h3B: letter_s = 8'h6A;  8'h42: letter_s = 8'h6B;  8'h4B: letter_s = 8'h6C;
            8'h3A: letter_s = 8'h6D;  8'h31: letter_s = 8'h6E;  8'h44: letter_s = 8'h6F;
            8'h4D: letter_s = 8'h70;  8'h15: letter_s = 8'h71;  8'h2D: letter_s = 8'h72;
            8'h1B: letter_s = 8'h73;  8'h2C: letter_s = 8'h74;  8'h3C: letter_s = 8'h75;
            8'h2A: letter_s = 8'h76;  8'h1D: letter_s = 8'h77;  8'h22: letter_s = 8'h78;
            8'h35: letter_s = 8'h79;  8'h1A: letter_s = 8'h7A;
            default: letter_s = 8'h00;
        endcase
    end

    // Digit, punctuation and whitespace lookup as {unshifted, shifted}.
    always_comb begin
        case (code)
            8'h45: sym_s = {8'h30, 8'h29};  8'h16: sym_s = {8'h31, 8'h21};
            8'h1E: sym_s = {8'h32, 8'h40};  8'h26: sym_s = {8'h33, 8'h23};
            8'h25: sym_s = {8'h34, 8'h24};  8'h2E: sym_s = {8'h35, 8'h25};
            8'h36: sym_s = {8'h36, 8'h5E};  8'h3D: sym_s = {8'h37, 8'h26};
            8'h3E: sym_s = {8'h38, 8'h2A};  8'h46: sym_s = {8'h39, 8'h28};
            8'h0E: sym_s = {8'h60, 8'h7E};  8'h4E: sym_s = {8'h2D, 8'h5F};
            8'h55: sym_s = {8'h3D, 8'h2B};  8'h54: sym_s = {8'h5B, 8'h7B};
            8'h5B: sym_s = {8'h5D, 8'h7D};  8'h5D: sym_s = {8'h5C, 8'h7C};
            8'h4C: sym_s = {8'h3B, 8'h3A};  8'h52: sym_s = {8'h27, 8'h22};
            8'h41: sym_s = {8'h2C, 8'h3C};  8'h49: sym_s = {8'h2E, 8'h3E};
            8'h4A: sym_s = {8'h2F, 8'h3F};
            SC_BKSP:  sym_s = {8'h08, 8'h08};
            SC_ENTER: sym_s = {8'h0D, 8'h0D};
            SC_SPACE: sym_s = {8'h20, 8'h20};
            default:  sym_s = {8'h00, 8'h00};
        endcase
    end

    // Extended keys never produce a character; letters follow shift XOR caps.
    always_comb begin
        if (ext) begin
            ascii = 8'h00;
        end else if (letter_s != 8'h00) begin
            ascii = (shift ^ caps) ? (letter_s - 8'h20) : letter_s;
        end else begin
            ascii = shift ? sym_s[7:0] : sym_s[15:8];
        end
    end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 prefix decoder with modifier tracking and a show-ahead event FIFO.
// Optional typematic repeat suppression is enabled by defining KBD_TYPEMATIC_FILTER_EN.
module kbd_event_decoder
    import kbd_pkg::*;
#(
    parameter int EVT_DEPTH = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             in_pop_n,
    output logic             evt_valid,
    input  logic             evt_rd,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic [7:0]       evt_ascii,
    output logic             shift,
    output logic             ctrl,
    output logic             alt,
    output logic             caps,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int             AW      = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(EVT_DEPTH);

    kbd_state_e       state_q, state_d;
    logic             pop_n_q, pop_n_d;
    logic             lshift_q, lshift_d, rshift_q, rshift_d;
    logic             ctrl_q, ctrl_d, alt_q, alt_d;
    logic             caps_held_q, caps_held_d, caps_q, caps_d, shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
    kbd_evt_t         mem_q [EVT_DEPTH];

    logic             accept_s, emit_s, ev_ext_s, ev_brk_s, repeat_s, push_s, pop_s;
    logic [7:0]       ascii_s;
    kbd_evt_t         evt_d;

    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign evt_valid = (count_s != {(AW+1){1'b0}});
    assign accept_s  = in_ready & pop_n_q & (count_s < DEPTH_C);
    assign pop_s     = evt_valid & evt_rd;

    kbd_ascii_map u_ascii (
        .code  (in_data),
        .ext   (ev_ext_s),
        .shift (shift_q),
        .caps  (caps_q),
        .ascii (ascii_s)
    );

    // Prefix FSM: control bytes abort, E0/F0 accumulate, anything else is a key.
    always_comb begin
        state_d  = state_q;
        emit_s   = 1'b0;
        ev_ext_s = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        ev_brk_s = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        if (!accept_s) begin
            state_d = state_q;
        end else if (is_ctrl_byte(in_data)) begin
            state_d = ST_IDLE;
        end else if (in_data == SC_EXT) begin
            state_d = ST_EXT;
        end else if (in_data == SC_BRK) begin
            case (state_q)
                ST_IDLE:    state_d = ST_BRK;
                ST_EXT:     state_d = ST_EXT_BRK;
                ST_BRK:     state_d = ST_BRK;
                ST_EXT_BRK: state_d = ST_EXT_BRK;
                default:    state_d = ST_IDLE;
            endcase
        end else begin
            emit_s  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Held-key levels follow every decoded key event, repeats included.
    always_comb begin
        lshift_d    = (emit_s && !ev_ext_s && in_data == SC_LSHIFT) ? !ev_brk_s : lshift_q;
        rshift_d    = (emit_s && !ev_ext_s && in_data == SC_RSHIFT) ? !ev_brk_s : rshift_q;
        ctrl_d      = (emit_s && in_data == SC_CTRL) ? !ev_brk_s : ctrl_q;
        alt_d       = (emit_s && in_data == SC_ALT) ? !ev_brk_s : alt_q;
        caps_held_d = (emit_s && !ev_ext_s && in_data == SC_CAPS) ? !ev_brk_s : caps_held_q;
        caps_d      = (emit_s && !ev_ext_s && !ev_brk_s && in_data == SC_CAPS && !caps_held_q)
                      ? !caps_q : caps_q;
        shift_d     = lshift_d | rshift_d;
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [511:0] held_q, held_d;
    logic [8:0]   key_idx_s;

    assign key_idx_s = {ev_ext_s, in_data};

    // A make of a key already down is an auto-repeat and is swallowed.
    always_comb begin
        held_d   = held_q;
        repeat_s = emit_s && !ev_brk_s && held_q[key_idx_s];
        if (emit_s) begin
            held_d[key_idx_s] = !ev_brk_s;
        end else begin
            held_d = held_q;
        end
    end

    // Per-key held table.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_q <= 512'd0;
        end else begin
            held_q <= held_d;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // FIFO write/read pointers and make-event counter.
    always_comb begin
        push_s    = emit_s & ~repeat_s;
        evt_d     = '{ext: ev_ext_s, brk: ev_brk_s, code: in_data, ascii: ascii_s};
        wr_ptr_d  = push_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
        cnt_d     = (push_s && !ev_brk_s) ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
        pop_n_d   = ~accept_s;
    end

    // Control state, modifier levels, pointers and handshake registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            pop_n_q     <= 1'b1;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            caps_held_q <= 1'b0;
            caps_q      <= 1'b0;
            shift_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            wr_ptr_q    <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
        end else begin
            state_q     <= state_d;
            pop_n_q     <= pop_n_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_q      <= ctrl_d;
            alt_q       <= alt_d;
            caps_held_q <= caps_held_d;
            caps_q      <= caps_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Event storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < EVT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= evt_d;
        end else begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    assign in_pop_n  = pop_n_q;
    assign evt_code  = mem_q[rd_ptr_q[AW-1:0]].code;
    assign evt_ext   = mem_q[rd_ptr_q[AW-1:0]].ext;
    assign evt_break = mem_q[rd_ptr_q[AW-1:0]].brk;
    assign evt_ascii = mem_q[rd_ptr_q[AW-1:0]].ascii;
    assign shift     = shift_q;
    assign ctrl      = ctrl_q;
    assign alt       = alt_q;
    assign caps      = caps_q;
    assign evt_cnt   = cnt_q;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed self-checking bench for kbd_event_decoder with a two-entry event FIFO.
`timescale 1ns/1ps
module tb_kbd_event_decoder;

    logic       clk = 1'b0;
    logic       clrn, in_ready, evt_rd;
    logic [7:0] in_data;
    logic       in_pop_n, evt_valid, evt_ext, evt_break, shift, ctrl, alt, caps;
    logic [7:0] evt_code, evt_ascii, evt_cnt;
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    kbd_event_decoder #(.EVT_DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .clrn(clrn), .in_ready(in_ready), .in_data(in_data), .in_pop_n(in_pop_n),
        .evt_valid(evt_valid), .evt_rd(evt_rd), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_break(evt_break), .evt_ascii(evt_ascii), .shift(shift), .ctrl(ctrl), .alt(alt),
        .caps(caps), .evt_cnt(evt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte until it is accepted, then confirm the pop strobe lasts one cycle.
    task automatic send(input logic [7:0] b);
        bit got = 1'b0;
        in_data  = b;
        in_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (in_pop_n === 1'b0) got = 1'b1;
        end
        in_ready = 1'b0;
        chk("accept", {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clk); #1;
            chk("pop_pulse_len", {31'd0, in_pop_n}, 32'd1);
        end
    endtask

    // Check the FIFO head and consume it.
    task automatic expect_evt(input string tag, input logic [7:0] code, input logic ext,
                              input logic brk, input logic [7:0] asc);
        chk({tag, ".valid"}, {31'd0, evt_valid}, 32'd1);
        chk({tag, ".code"},  {24'd0, evt_code},  {24'd0, code});
        chk({tag, ".ext"},   {31'd0, evt_ext},   {31'd0, ext});
        chk({tag, ".brk"},   {31'd0, evt_break}, {31'd0, brk});
        chk({tag, ".ascii"}, {24'd0, evt_ascii}, {24'd0, asc});
        evt_rd = 1'b1;
        @(posedge clk); #1;
        evt_rd = 1'b0;
    endtask

    task automatic do_reset();
        in_ready = 1'b0;
        evt_rd   = 1'b0;
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bit stall_bad;
        clrn = 1'b1; in_ready = 1'b0; evt_rd = 1'b0; in_data = 8'h00;
        #2 clrn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) clrn = 1'b1;
        @(posedge clk); #1;
        chk("rst.pop_n", {31'd0, in_pop_n}, 32'd1);
        chk("rst.valid", {31'd0, evt_valid}, 32'd0);
        chk("rst.code", {24'd0, evt_code}, 32'd0);
        chk("rst.flags", {28'd0, evt_ext, evt_break, shift, ctrl}, 32'd0);
        chk("rst.ascii", {24'd0, evt_ascii}, 32'd0);
        chk("rst.alt_caps", {30'd0, alt, caps}, 32'd0);
        chk("rst.cnt", {24'd0, evt_cnt}, 32'd0);

        // Plain make and break.
        send(8'h1C); expect_evt("a_make", 8'h1C, 1'b0, 1'b0, 8'h61);
        send(8'hF0);
        chk("prefix_no_evt", {31'd0, evt_valid}, 32'd0);
        send(8'h1C); expect_evt("a_break", 8'h1C, 1'b0, 1'b1, 8'h61);
        chk("cnt_after_a", {24'd0, evt_cnt}, 32'd1);

        // Shift held across letters and punctuation.
        send(8'h12); expect_evt("lsh_make", 8'h12, 1'b0, 1'b0, 8'h00);
        chk("shift_on", {31'd0, shift}, 32'd1);
        send(8'h1C); expect_evt("A_make", 8'h1C, 1'b0, 1'b0, 8'h41);
        send(8'h16); expect_evt("bang", 8'h16, 1'b0, 1'b0, 8'h21);
        send(8'hF0); send(8'h1C); expect_evt("A_break", 8'h1C, 1'b0, 1'b1, 8'h41);
        chk("shift_still", {31'd0, shift}, 32'd1);
        send(8'hF0); send(8'h12); expect_evt("lsh_break", 8'h12, 1'b0, 1'b1, 8'h00);
        chk("shift_off", {31'd0, shift}, 32'd0);
        chk("cnt_after_shift", {24'd0, evt_cnt}, 32'd4);

        // Caps lock with auto-repeat.
        send(8'h58); expect_evt("caps_make", 8'h58, 1'b0, 1'b0, 8'h00);
        chk("caps_on", {31'd0, caps}, 32'd1);
        for (int r = 0; r < 2; r++) begin
            send(8'h58);
`ifdef KBD_TYPEMATIC_FILTER_EN
            chk("caps_rep_filtered", {31'd0, evt_valid}, 32'd0);
`else
            expect_evt("caps_rep", 8'h58, 1'b0, 1'b0, 8'h00);
`endif
            chk("caps_rep_level", {31'd0, caps}, 32'd1);
        end
        send(8'hF0); send(8'h58); expect_evt("caps_break", 8'h58, 1'b0, 1'b1, 8'h00);
        chk("caps_after_break", {31'd0, caps}, 32'd1);
        send(8'h1C); expect_evt("caps_A", 8'h1C, 1'b0, 1'b0, 8'h41);

        // Extended key make/break.
        send(8'hE0); send(8'h75); expect_evt("ext_make", 8'h75, 1'b1, 1'b0, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h75); expect_evt("ext_break", 8'h75, 1'b1, 1'b1, 8'h00);

        // Ctrl (right, extended release) and alt.
        send(8'h14); expect_evt("ctrl_make", 8'h14, 1'b0, 1'b0, 8'h00);
        chk("ctrl_on", {31'd0, ctrl}, 32'd1);
        send(8'hE0); send(8'hF0); send(8'h14); expect_evt("ctrl_break", 8'h14, 1'b1, 1'b1, 8'h00);
        chk("ctrl_off", {31'd0, ctrl}, 32'd0);
        send(8'h11); expect_evt("alt_make", 8'h11, 1'b0, 1'b0, 8'h00);
        chk("alt_on", {31'd0, alt}, 32'd1);
        send(8'hF0); send(8'h11); expect_evt("alt_break", 8'h11, 1'b0, 1'b1, 8'h00);
        chk("alt_off", {31'd0, alt}, 32'd0);
`ifdef KBD_TYPEMATIC_FILTER_EN
        chk("cnt_mid", {24'd0, evt_cnt}, 32'd9);
`else
        chk("cnt_mid", {24'd0, evt_cnt}, 32'd11);
`endif

        // Control bytes abort a pending prefix.
        send(8'hE0); send(8'hAA);
        chk("ctrl_byte_no_evt", {31'd0, evt_valid}, 32'd0);
        send(8'h1C); expect_evt("after_AA", 8'h1C, 1'b0, 1'b0, 8'h41);
        send(8'hF0); send(8'hFA); send(8'h1C); expect_evt("after_FA", 8'h1C, 1'b0, 1'b0, 8'h41);

        // Reset mid-sequence with a queued event and caps on.
        send(8'h1C); send(8'hE0); send(8'hF0);
        do_reset();
        chk("mid_rst.valid", {31'd0, evt_valid}, 32'd0);
        chk("mid_rst.caps", {31'd0, caps}, 32'd0);
        chk("mid_rst.cnt", {24'd0, evt_cnt}, 32'd0);
        send(8'h1C); expect_evt("post_rst", 8'h1C, 1'b0, 1'b0, 8'h61);

        // Full two-entry FIFO stalls intake.
        send(8'h1C); send(8'h32);
        stall_bad = 1'b0;
        in_data = 8'h21; in_ready = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (in_pop_n !== 1'b1) stall_bad = 1'b1;
        end
        in_ready = 1'b0;
        chk("full_stall", {31'd0, stall_bad}, 32'd0);
        expect_evt("q0", 8'h1C, 1'b0, 1'b0, 8'h61);
        send(8'h21); expect_evt("q1", 8'h32, 1'b0, 1'b0, 8'h62);
        send(8'h23); expect_evt("q2", 8'h21, 1'b0, 1'b0, 8'h63);
        send(8'h24); expect_evt("q3", 8'h23, 1'b0, 1'b0, 8'h64);
        expect_evt("q4", 8'h24, 1'b0, 1'b0, 8'h65);
        chk("drained", {31'd0, evt_valid}, 32'd0);
        evt_rd = 1'b1; @(posedge clk); #1; evt_rd = 1'b0;
        chk("rd_empty", {31'd0, evt_valid}, 32'd0);
        send(8'h1C); expect_evt("after_empty_rd", 8'h1C, 1'b0, 1'b0, 8'h61);
        chk("empty_again", {31'd0, evt_valid}, 32'd0);
        chk("cnt_fifo", {24'd0, evt_cnt}, 32'd7);

        // Typematic repeats of a letter.
        do_reset();
        send(8'h1C); expect_evt("tm_first", 8'h1C, 1'b0, 1'b0, 8'h61);
        for (int r = 0; r < 3; r++) begin
            send(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
            chk("tm_filtered", {31'd0, evt_valid}, 32'd0);
`else
            expect_evt("tm_rep", 8'h1C, 1'b0, 1'b0, 8'h61);
`endif
        end
        send(8'hF0); send(8'h1C); expect_evt("tm_break", 8'h1C, 1'b0, 1'b1, 8'h61);
`ifdef KBD_TYPEMATIC_FILTER_EN
        chk("tm_cnt", {24'd0, evt_cnt}, 32'd1);
`else
        chk("tm_cnt", {24'd0, evt_cnt}, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
